// File: rtl/scramble_seed_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : scramble_seed_scheduler_if
//  Brief    : Host key channel and generator seed channel of the seed scheduler.
//  Revision : 1.0  initial release
// ============================================================================
interface scramble_seed_scheduler_if #(
    parameter int SEED_W = 16
);
    logic [31:0]       key_in;
    logic              key_valid;
    logic              key_ready;
    logic [SEED_W-1:0] seed_out;
    logic              seed_strobe;
    logic              seed_valid;

    modport master (
        output key_in, key_valid,
        input  key_ready, seed_out, seed_strobe, seed_valid
    );

    modport slave (
        input  key_in, key_valid,
        output key_ready, seed_out, seed_strobe, seed_valid
    );
endinterface
`default_nettype wire

// File: rtl/scramble_seed_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : scramble_seed_scheduler
//  Brief    : Swaps host keys at vertical blanking, derives a per-field seed
//             during blanking and publishes it at the start of active video.
//  Revision : 1.0  initial release
// ============================================================================
module scramble_seed_scheduler #(
    parameter int SEED_W      = 16,
    parameter int ROUNDS      = 8,
    parameter int FIELD_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   V,
    input  logic                   scramble_en,
    scramble_seed_scheduler_if.slave bus,
    output logic [FIELD_CNT_W-1:0] field_cnt,
    output logic                   late_err,
    output logic                   busy
);

    localparam int                 c_RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [c_RND_W-1:0] c_LAST_RND = c_RND_W'(ROUNDS - 1);
    localparam logic [31:0]        c_GOLDEN   = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DERIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_prev_v;
    logic                 r_key_ready;
    logic                 r_pending;
    logic [31:0]          r_pending_key;
    logic [31:0]          r_active_key;
    logic [FIELD_CNT_W-1:0] r_field_cnt;
    logic [31:0]          r_x;
    logic [c_RND_W-1:0]   r_round;
    logic [SEED_W-1:0]    r_shadow;
    logic [SEED_W-1:0]    r_seed_out;
    logic                 r_seed_strobe;
    logic                 r_seed_valid;
    logic                 r_late_err;
    logic                 r_busy;

    logic                 w_v_rise;
    logic                 w_v_fall;
    logic                 w_xfer;
    logic                 w_swap;
    logic [31:0]          w_key_eff;
    logic [FIELD_CNT_W-1:0] w_cnt_eff;
    logic [31:0]          w_seed_in;
    logic [31:0]          w_x_next;
    logic [SEED_W-1:0]    w_slice;
    logic                 w_load;
    logic                 w_step;
    logic                 w_finish;
    logic                 w_abort;
    logic                 w_publish;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    assign w_v_rise  = V & ~r_prev_v;
    assign w_v_fall  = ~V & r_prev_v;
    assign w_xfer    = bus.key_valid & r_key_ready;
    assign w_swap    = w_v_rise & r_pending;

    // A derivation started at the swap boundary must already see the new key and count.
    assign w_key_eff = w_swap ? r_pending_key : r_active_key;
    assign w_cnt_eff = w_swap ? '0 : r_field_cnt;
    assign w_seed_in = w_key_eff ^ 32'(w_cnt_eff) ^ c_GOLDEN;
    assign w_x_next  = xs_step(r_x);
    assign w_slice   = w_x_next[SEED_W-1:0];

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_v_rise && scramble_en) begin
                    w_state_next = ST_DERIVE;
                    w_load       = 1'b1;
                end
            end
            ST_DERIVE: begin
                if (w_v_fall) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (r_round == c_LAST_RND) begin
                        w_state_next = ST_DONE;
                        w_finish     = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (w_v_fall) begin
                    w_state_next = ST_IDLE;
                    w_publish    = scramble_en;
                end else if (w_v_rise) begin
                    // Blanking re-entered without active video: start over.
                    if (scramble_en) begin
                        w_state_next = ST_DERIVE;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_v      <= V;
            r_state       <= ST_IDLE;
            r_key_ready   <= 1'b1;
            r_pending     <= 1'b0;
            r_pending_key <= '0;
            r_active_key  <= '0;
            r_field_cnt   <= '0;
            r_x           <= '0;
            r_round       <= '0;
            r_shadow      <= '0;
            r_seed_out    <= '0;
            r_seed_strobe <= 1'b0;
            r_seed_valid  <= 1'b0;
            r_late_err    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_prev_v      <= V;
            r_state       <= w_state_next;
            r_seed_strobe <= w_publish;
            r_late_err    <= w_abort;

            if (w_swap) begin
                r_active_key <= r_pending_key;
                r_pending    <= 1'b0;
                r_key_ready  <= 1'b1;
            end else if (w_xfer) begin
                r_pending_key <= bus.key_in;
                r_pending     <= 1'b1;
                r_key_ready   <= 1'b0;
            end

            if (w_swap) begin
                r_field_cnt <= '0;
            end else if (w_v_fall) begin
                r_field_cnt <= r_field_cnt + 1'b1;
            end

            if (w_load) begin
                r_x     <= w_seed_in;
                r_round <= '0;
                r_busy  <= 1'b1;
            end else if (w_step) begin
                r_x     <= w_x_next;
                r_round <= r_round + c_RND_W'(1);
            end

            // An all-zero seed would lock the downstream LFSR.
            if (w_finish) begin
                r_shadow <= (w_slice == '0) ? SEED_W'(1) : w_slice;
                r_busy   <= 1'b0;
            end

            if (w_abort) begin
                r_busy <= 1'b0;
            end

            if (w_publish) begin
                r_seed_out   <= r_shadow;
                r_seed_valid <= 1'b1;
            end else if (w_v_rise) begin
                r_seed_valid <= 1'b0;
            end
        end
    end

    assign bus.key_ready   = r_key_ready;
    assign bus.seed_out    = r_seed_out;
    assign bus.seed_strobe = r_seed_strobe;
    assign bus.seed_valid  = r_seed_valid;
    assign field_cnt       = r_field_cnt;
    assign late_err        = r_late_err;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_scramble_seed_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scramble_seed_scheduler
//  Brief    : Directed self-checking bench for scramble_seed_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scramble_seed_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        V;
    logic        scramble_en;
    logic [15:0] field_cnt;
    logic        late_err;
    logic        busy;
    logic [3:0]  field_cnt4;
    logic        late_err4;
    logic        busy4;

    int          n_checks;
    int          n_pass;
    logic [15:0] exp_cnt;
    int          exp4;

    scramble_seed_scheduler_if #(.SEED_W(16)) bus ();
    scramble_seed_scheduler_if #(.SEED_W(16)) bus4 ();

    scramble_seed_scheduler #(.SEED_W(16), .ROUNDS(8), .FIELD_CNT_W(16)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .V           (V),
        .scramble_en (scramble_en),
        .bus         (bus),
        .field_cnt   (field_cnt),
        .late_err    (late_err),
        .busy        (busy)
    );

    scramble_seed_scheduler #(.SEED_W(16), .ROUNDS(8), .FIELD_CNT_W(4)) u_dut_w4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .V           (V),
        .scramble_en (scramble_en),
        .bus         (bus4),
        .field_cnt   (field_cnt4),
        .late_err    (late_err4),
        .busy        (busy4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] model_raw(input logic [31:0] key, input logic [15:0] cnt);
        logic [31:0] x;
        x = key ^ {16'h0000, cnt} ^ 32'h9E37_79B9;
        for (int r = 0; r < 8; r++) x = xs32(x);
        return x;
    endfunction

    function automatic logic [15:0] seed_of(input logic [31:0] key, input logic [15:0] cnt);
        logic [31:0] x;
        x = model_raw(key, cnt);
        return (x[15:0] == 16'h0000) ? 16'h0001 : x[15:0];
    endfunction

    // One field: `blank` cycles of V=1 then `act` cycles of V=0, sampled on falling edges.
    task automatic run_field(input int blank, input int act, input logic kv0, input logic [31:0] k0,
                             output int busy_n, output int strobe_n, output int late_n,
                             output int late_at, output logic [15:0] sval,
                             output logic kr0, output logic [15:0] cnt0);
        busy_n = 0; strobe_n = 0; late_n = 0; late_at = -1; sval = 16'h0; kr0 = 1'b0; cnt0 = 16'h0;
        for (int i = 0; i < blank + act; i++) begin
            V             = (i < blank);
            bus.key_valid = (i == 0) && kv0;
            bus.key_in    = k0;
            @(negedge clk);
            if (i == 0) begin
                kr0  = bus.key_ready;
                cnt0 = field_cnt;
            end
            busy_n   += int'(busy);
            strobe_n += int'(bus.seed_strobe);
            late_n   += int'(late_err);
            if (bus.seed_strobe) sval = bus.seed_out;
            if (late_err && late_at < 0) late_at = i;
        end
        bus.key_valid = 1'b0;
        exp4++;
    endtask

    initial begin
        int          bn, sn, ln, la, strobes;
        logic [15:0] sv, c0;
        logic        kr;
        logic [31:0] zk, raw;
        logic        found;

        n_checks = 0; n_pass = 0; exp_cnt = 16'd0; exp4 = 0;
        reset_n = 1'b0; V = 1'b1; scramble_en = 1'b1;
        bus.key_in = 32'h0; bus.key_valid = 1'b0;
        bus4.key_in = 32'h0; bus4.key_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_key_ready", bus.key_ready, 1);
        check_eq("rst_seed_out", bus.seed_out, 0);
        check_eq("rst_strobe", bus.seed_strobe, 0);
        check_eq("rst_seed_valid", bus.seed_valid, 0);
        check_eq("rst_field_cnt", field_cnt, 0);
        check_eq("rst_late_err", late_err, 0);
        check_eq("rst_busy", busy, 0);

        // Release while blanking: no rising edge may be seen.
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("no_spurious_rise_busy", busy, 0);
        V = 1'b0;
        strobes = 0;
        repeat (5) begin
            @(negedge clk);
            strobes += int'(bus.seed_strobe);
        end
        exp_cnt = 16'd1; exp4 = 1;
        check_eq("first_fall_no_strobe", strobes, 0);
        check_eq("first_fall_cnt", field_cnt, exp_cnt);

        for (int f = 0; f < 3; f++) begin
            run_field(12, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
            check_eq("k0_busy_cycles", bn, 8);
            check_eq("k0_strobe_count", sn, 1);
            check_eq("k0_seed", sv, seed_of(32'h0, exp_cnt));
            check_eq("k0_seed_valid", bus.seed_valid, 1);
            exp_cnt++;
            check_eq("k0_field_cnt", field_cnt, exp_cnt);
        end

        bus.key_in = 32'hDEAD_BEEF; bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        check_eq("key_ready_drop", bus.key_ready, 0);
        run_field(12, 10, 1'b0, 32'hDEAD_BEEF, bn, sn, ln, la, sv, kr, c0);
        check_eq("swap_key_ready_back", kr, 1);
        check_eq("swap_cnt_zero", c0, 0);
        check_eq("swap_seed", sv, seed_of(32'hDEAD_BEEF, 16'd0));
        exp_cnt = 16'd1;

        // Key offered exactly in the V_rise cycle waits for the next boundary.
        run_field(12, 10, 1'b1, 32'h1357_9BDF, bn, sn, ln, la, sv, kr, c0);
        check_eq("rise_xfer_ready_low", kr, 0);
        check_eq("rise_xfer_old_key_seed", sv, seed_of(32'hDEAD_BEEF, 16'd1));
        run_field(12, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        check_eq("deferred_cnt_zero", c0, 0);
        check_eq("deferred_key_ready", kr, 1);
        check_eq("deferred_seed", sv, seed_of(32'h1357_9BDF, 16'd0));
        exp_cnt = 16'd1;

        run_field(5, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        check_eq("late_pulse_count", ln, 1);
        check_eq("late_pulse_at", la, 5);
        check_eq("late_no_strobe", sn, 0);
        check_eq("late_seed_kept", bus.seed_out, seed_of(32'h1357_9BDF, 16'd0));
        check_eq("late_seed_valid", bus.seed_valid, 0);
        exp_cnt = 16'd2;
        run_field(12, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        check_eq("after_late_seed", sv, seed_of(32'h1357_9BDF, 16'd2));
        check_eq("after_late_no_err", ln, 0);
        exp_cnt = 16'd3;

        found = 1'b0; zk = 32'h0;
        for (int i = 0; i < (1 << 22) && !found; i++) begin
            raw = model_raw(32'(i), 16'd0);
            if (raw[15:0] == 16'h0000) begin
                found = 1'b1;
                zk    = 32'(i);
            end
        end
        check_eq("zero_key_found", found, 1);
        bus.key_in = zk; bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        run_field(12, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        check_eq("lockup_guard_seed", sv, 16'h0001);
        exp_cnt = 16'd1;

        scramble_en = 1'b0;
        strobes = 0;
        bn = 0;
        while ((exp4 % 16) != 15) begin
            run_field(3, 3, 1'b0, 32'h0, ln, sn, ln, la, sv, kr, c0);
            strobes += sn;
            exp_cnt++;
        end
        check_eq("w4_cnt_15", field_cnt4, 4'd15);
        run_field(3, 3, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        strobes += sn;
        exp_cnt++;
        check_eq("w4_cnt_wrap", field_cnt4, 4'd0);
        check_eq("disabled_no_strobe", strobes, 0);
        check_eq("disabled_no_busy", bn, 0);
        check_eq("disabled_seed_valid", bus.seed_valid, 0);
        check_eq("disabled_field_cnt", field_cnt, exp_cnt);

        // Reset mid-derivation with a key still pending.
        scramble_en = 1'b1;
        V = 1'b1; bus.key_in = 32'hCAFE_F00D; bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_derive_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_key_ready", bus.key_ready, 1);
        check_eq("async_rst_seed_out", bus.seed_out, 0);
        check_eq("async_rst_seed_valid", bus.seed_valid, 0);
        check_eq("async_rst_field_cnt", field_cnt, 0);
        check_eq("async_rst_field_cnt4", field_cnt4, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        V = 1'b0;
        strobes = 0;
        repeat (6) begin
            @(negedge clk);
            strobes += int'(bus.seed_strobe);
        end
        check_eq("post_rst_fall_no_strobe", strobes, 0);
        run_field(12, 10, 1'b0, 32'h0, bn, sn, ln, la, sv, kr, c0);
        check_eq("post_rst_pending_lost", c0, 1);
        check_eq("post_rst_seed", sv, seed_of(32'h0, 16'd1));
        check_eq("post_rst_strobe_count", sn, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
